// File: rtl/loa_pkg.sv
// ----------------------------------------------------------------------------
// loa_pkg: shared helpers for the LOA approximate subtractor. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package loa_pkg;

  localparam int LOA_MAX_W = 32;

  function automatic bit loa_border_legal(input int bitwidth, input int border);
    return (bitwidth >= 2) && (bitwidth <= LOA_MAX_W) &&
           (border >= 1) && (border <= bitwidth - 1);
  endfunction

  // Zero-extended operands give the correct two's-complement difference in
  // the low bits; callers keep the BITWIDTH+1 bits they need.
  function automatic logic [LOA_MAX_W:0] loa_sub_exact(input logic [LOA_MAX_W-1:0] a,
                                                        input logic [LOA_MAX_W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/loa_sub_core.sv
// ----------------------------------------------------------------------------
// loa_sub_core: combinational LOA subtract, low OR part and high add part. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module loa_sub_core #(
  parameter int BITWIDTH = 8,
  parameter int BORDER   = 2
) (
  input  logic [BORDER-1:0]          lo_a,
  input  logic [BORDER-1:0]          lo_b,
  output logic [BORDER-1:0]          lo_r,
  output logic                       cin,
  input  logic [BITWIDTH-BORDER-1:0] hi_a,
  input  logic [BITWIDTH-BORDER-1:0] hi_b,
  input  logic                       hi_cin,
  output logic [BITWIDTH-BORDER:0]   hi_sum
);

  localparam int HI_W = BITWIDTH - BORDER;

  // Subtraction as a + ~b; the +1 of the negation is deliberately dropped.
  assign lo_r   = lo_a | ~lo_b;
  assign cin    = lo_a[BORDER-1] & ~lo_b[BORDER-1];
  assign hi_sum = {1'b0, hi_a} + {1'b0, ~hi_b} + (HI_W + 1)'(hi_cin);

endmodule

`default_nettype wire

// File: rtl/loa_sub_pipe.sv
// ----------------------------------------------------------------------------
// loa_sub_pipe: 2-stage valid/ready LOA approximate a-b with exact shadow. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module loa_sub_pipe
  import loa_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int BORDER   = 2,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH:0]   diff,
  output logic [BITWIDTH:0]   diff_exact,
  input  logic                err_clr,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int HI_W = BITWIDTH - BORDER;

  generate
    if (!loa_border_legal(BITWIDTH, BORDER)) begin : g_bad_border
      $error("loa_sub_pipe: illegal BITWIDTH/BORDER combination");
    end
  endgenerate

  logic                r_s1_valid;
  logic [BITWIDTH-1:0] r_s1_a;
  logic [BITWIDTH-1:0] r_s1_b;
  logic [BORDER-1:0]   r_s1_lo;
  logic                r_s1_cin;
  logic [BITWIDTH:0]   r_s1_exact;
  logic                r_s2_valid;
  logic [BITWIDTH:0]   r_diff;
  logic [BITWIDTH:0]   r_diff_exact;
  logic [ERRCNT_W-1:0] r_err_cnt;

  logic [BORDER-1:0]   w_lo;
  logic                w_cin;
  logic [HI_W:0]       w_hi_sum;
  logic [LOA_MAX_W:0]  w_exact_full;
  logic                w_s1_adv;
  logic                w_s2_adv;
  logic                w_out_fire;
  logic                w_unused;

  assign w_exact_full = loa_sub_exact(LOA_MAX_W'(a), LOA_MAX_W'(b));
  assign w_unused     = ^w_exact_full ^ ^r_s1_a[BORDER-1:0] ^ ^r_s1_b[BORDER-1:0];

  loa_sub_core #(
    .BITWIDTH (BITWIDTH),
    .BORDER   (BORDER)
  ) u_core (
    .lo_a   (a[BORDER-1:0]),
    .lo_b   (b[BORDER-1:0]),
    .lo_r   (w_lo),
    .cin    (w_cin),
    .hi_a   (r_s1_a[BITWIDTH-1:BORDER]),
    .hi_b   (r_s1_b[BITWIDTH-1:BORDER]),
    .hi_cin (r_s1_cin),
    .hi_sum (w_hi_sum)
  );

  assign w_s2_adv   = ~r_s2_valid | out_ready;
  assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
  assign w_out_fire = r_s2_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_lo    <= '0;
      r_s1_cin   <= 1'b0;
      r_s1_exact <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a     <= a;
        r_s1_b     <= b;
        r_s1_lo    <= w_lo;
        r_s1_cin   <= w_cin;
        r_s1_exact <= w_exact_full[BITWIDTH:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_diff       <= '0;
      r_diff_exact <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_diff       <= {~w_hi_sum[HI_W], w_hi_sum[HI_W-1:0], r_s1_lo};
        r_diff_exact <= r_s1_exact;
      end
    end
  end

  // Clear beats a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_out_fire && (r_diff != r_diff_exact) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign in_ready   = w_s1_adv;
  assign out_valid  = r_s2_valid;
  assign diff       = r_diff;
  assign diff_exact = r_diff_exact;
  assign err_cnt    = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_loa_sub_pipe.sv
// ----------------------------------------------------------------------------
// tb_loa_sub_pipe: randomized and directed checks of loa_sub_pipe. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_loa_sub_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       err_clr;
  logic [7:0] a;
  logic [7:0] b;

  logic        in_ready, out_valid;
  logic [8:0]  diff, diff_exact;
  logic [15:0] err_cnt;
  logic        in_ready2, out_valid2;
  logic [8:0]  diff2, diff_exact2;
  logic [1:0]  err_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_q[$];
  logic [17:0] exp_front;
  int          exp_err  = 0;
  int          exp_err2 = 0;

  bit         obs_in_fire, obs_out_fire, obs_underflow, obs_ov, obs_ir;
  logic [8:0] obs_diff, obs_exact, obs_diff2;

  always #5 clk = ~clk;

  loa_sub_pipe #(.BITWIDTH(8), .BORDER(2), .ERRCNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .diff_exact(diff_exact), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  loa_sub_pipe #(.BITWIDTH(8), .BORDER(2), .ERRCNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
    .diff(diff2), .diff_exact(diff_exact2), .err_clr(err_clr), .err_cnt(err_cnt2)
  );

  // Reference: low bits OR'd, carry from the top approximate bit, plain add above.
  function automatic logic [8:0] model_approx(input logic [7:0] x, input logic [7:0] y);
    int nb, low, c, hs, cout;
    nb   = (~y) & 255;
    low  = (x | nb) & 3;
    c    = ((x >> 1) & 1) & ((nb >> 1) & 1);
    hs   = (x >> 2) + (nb >> 2) + c;
    cout = (hs >> 6) & 1;
    return 9'(((1 - cout) << 8) | ((hs & 63) << 2) | low);
  endfunction

  function automatic logic [8:0] model_exact(input logic [7:0] x, input logic [7:0] y);
    return 9'(int'(x) - int'(y));
  endfunction

  task automatic step(input bit v, input logic [7:0] aa, input logic [7:0] bb,
                      input bit ordy, input bit clr);
    @(negedge clk);
    in_valid  = v;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    err_clr   = clr;
    #1;
    obs_in_fire   = in_valid && in_ready;
    obs_out_fire  = out_valid && out_ready;
    obs_ir        = in_ready;
    obs_ov        = out_valid;
    obs_diff      = diff;
    obs_exact     = diff_exact;
    obs_diff2     = diff2;
    obs_underflow = 1'b0;
    if (obs_out_fire) begin
      if (exp_q.size() == 0) begin
        obs_underflow = 1'b1;
        exp_front     = '0;
      end else begin
        exp_front = exp_q.pop_front();
      end
    end
    if (clr) begin
      exp_err  = 0;
      exp_err2 = 0;
    end else if (obs_out_fire && !obs_underflow && (exp_front[17:9] != exp_front[8:0])) begin
      if (exp_err < 65535) exp_err++;
      if (exp_err2 < 3) exp_err2++;
    end
    if (obs_in_fire) exp_q.push_back({model_approx(aa, bb), model_exact(aa, bb)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    n_checks++; if (diff !== 9'd0 || diff_exact !== 9'd0) begin n_fail++; $display("FAIL reset_data got %h/%h want 000/000", diff, diff_exact); end
    n_checks++; if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || err_cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_sat got ir=%b ov=%b cnt=%0d want 1/0/0", in_ready2, out_valid2, err_cnt2); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); exp_err = 0; exp_err2 = 0;
  endtask

  task automatic test_directed();
    logic [7:0] va[4]  = '{8'd3, 8'd5, 8'd0, 8'd0};
    logic [7:0] vb[4]  = '{8'd0, 8'd3, 8'd1, 8'd0};
    logic [8:0] ed[4]  = '{9'h003, 9'h001, 9'h1FE, 9'h1FF};
    logic [8:0] ex[4]  = '{9'h003, 9'h002, 9'h1FF, 9'h000};
    int         ee[4]  = '{0, 1, 2, 3};
    int lat;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, va[i], vb[i], 1'b1, 1'b0);
      n_checks++; if (!obs_in_fire) begin n_fail++; $display("FAIL dir_accept[%0d] got 0 want 1", i); end
      lat = 0;
      for (int k = 1; k <= 5; k++) begin
        step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
        if (obs_out_fire) begin lat = k; break; end
      end
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL dir_latency[%0d] got %0d want 2", i, lat); end
      n_checks++; if (obs_diff !== ed[i]) begin n_fail++; $display("FAIL dir_diff[%0d] got %h want %h", i, obs_diff, ed[i]); end
      n_checks++; if (obs_exact !== ex[i]) begin n_fail++; $display("FAIL dir_exact[%0d] got %h want %h", i, obs_exact, ex[i]); end
      n_checks++; if (err_cnt !== 16'(ee[i])) begin n_fail++; $display("FAIL dir_err_cnt[%0d] got %0d want %0d", i, err_cnt, ee[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pa[4], pb[4];
    logic [8:0] held;
    int idx = 0, n_out = 0, first = -1, last = -1;
    for (int i = 0; i < 4; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
    for (int s = 0; s < 6; s++) begin
      step(1'b1, pa[idx], pb[idx], 1'b0, 1'b0);
      if (obs_in_fire) idx++;
    end
    n_checks++; if (idx != 2) begin n_fail++; $display("FAIL bp_accepts got %0d want 2", idx); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
    held = (exp_q.size() > 0) ? exp_q[0][17:9] : 9'h0;
    for (int s = 0; s < 3; s++) begin
      step(1'b1, pa[idx], pb[idx], 1'b0, 1'b0);
      n_checks++; if (obs_diff !== held) begin n_fail++; $display("FAIL bp_hold[%0d] got %h want %h", s, obs_diff, held); end
    end
    for (int s = 0; s < 12 && n_out < 4; s++) begin
      step(idx < 4, pa[idx % 4], pb[idx % 4], 1'b1, 1'b0);
      if (obs_in_fire) idx++;
      if (obs_out_fire) begin
        n_out++;
        if (first < 0) first = s;
        last = s;
        n_checks++;
        if (obs_underflow || obs_diff !== exp_front[17:9] || obs_exact !== exp_front[8:0]) begin
          n_fail++; $display("FAIL bp_order[%0d] got %h/%h want %h/%h", n_out, obs_diff, obs_exact, exp_front[17:9], exp_front[8:0]);
        end
      end
    end
    n_checks++; if (n_out != 4 || last - first != 3) begin n_fail++; $display("FAIL bp_drain got %0d outs over %0d cycles want 4 over 4", n_out, last - first + 1); end
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    n_checks++; if (obs_out_fire || exp_q.size() != 0) begin n_fail++; $display("FAIL bp_no_dup got fire=%b pending=%0d want 0/0", obs_out_fire, exp_q.size()); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 300; s++) begin
      step(($urandom % 4) != 0, 8'($urandom), 8'($urandom), ($urandom % 4) != 0, ($urandom % 50) == 0);
      if (obs_out_fire) begin
        n_checks++;
        if (obs_underflow || obs_diff !== exp_front[17:9] || obs_exact !== exp_front[8:0] || obs_diff2 !== exp_front[17:9]) begin
          n_fail++; $display("FAIL rnd_data[%0d] got %h/%h/%h want %h/%h", s, obs_diff, obs_exact, obs_diff2, exp_front[17:9], exp_front[8:0]);
        end
      end
      n_checks++;
      if (err_cnt !== 16'(exp_err) || err_cnt2 !== 2'(exp_err2)) begin
        n_fail++; $display("FAIL rnd_err_cnt[%0d] got %0d/%0d want %0d/%0d", s, err_cnt, err_cnt2, exp_err, exp_err2);
      end
    end
    for (int s = 0; s < 4; s++) begin
      step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
      if (obs_out_fire) begin
        n_checks++;
        if (obs_underflow || obs_diff !== exp_front[17:9] || obs_exact !== exp_front[8:0]) begin
          n_fail++; $display("FAIL rnd_drain[%0d] got %h/%h want %h/%h", s, obs_diff, obs_exact, exp_front[17:9], exp_front[8:0]);
        end
      end
    end
    n_checks++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_empty got pending=%0d ov=%b want 0/0", exp_q.size(), out_valid); end
  endtask

  task automatic test_err_clr();
    step(1'b1, 8'd5, 8'd3, 1'b1, 1'b0);
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
    n_checks++; if (!obs_out_fire) begin n_fail++; $display("FAIL clr_fire got 0 want 1"); end
    n_checks++; if (err_cnt !== 16'd0 || err_cnt2 !== 2'd0) begin n_fail++; $display("FAIL clr_wins got %0d/%0d want 0/0", err_cnt, err_cnt2); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) step(1'b1, 8'd0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
    n_checks++; if (err_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_err_cnt2 got %0d want 3", err_cnt2); end
    n_checks++; if (err_cnt !== 16'd5) begin n_fail++; $display("FAIL sat_err_cnt got %0d want 5", err_cnt); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_full got ov=%b ir=%b want 1/0", out_valid, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_async got ov=%b ir=%b cnt=%0d want 0/1/0", out_valid, in_ready, err_cnt); end
    exp_q.delete(); exp_err = 0; exp_err2 = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step(1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
      n_checks++; if (obs_ov) begin n_fail++; $display("FAIL rstmid_stale[%0d] got ov=1 want 0", s); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_err_clr();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
